i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target_pkg.sv | 11 +
 rtl/i2c_bus_sync.sv | 58 +++++
 rtl/i2c_target.sv | 143 ++++++++++++++
 tb/tb_i2c_target.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: state encoding and status bit positions shared by the I2C target.
package i2c_target_pkg;
  localparam int STATE_W = 4;
  typedef enum logic [STATE_W-1:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;
  localparam int ST_BUSY      = 0;
  localparam int ST_ADDRESSED = 1;
  localparam int ST_NACK      = 2;
  localparam int ST_STATE_LSB = 3;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: SCL/SDA synchronizers, optional 3-sample majority filter
// (I2C_TARGET_GLITCH_FILTER_EN), SCL edge and START/STOP detection.
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  logic [1:0] scl_s, sda_s;
  logic scl, scl_q, sda_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
    end else begin
      scl_s <= {scl_s[0], i_scl};
      sda_s <= {sda_s[0], i_sda};
    end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic scl_m, sda_m;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_m <= 1'b1;
      sda_m <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_s[1]};
      sda_h <= {sda_h[0], sda_s[1]};
      scl_m <= (scl_s[1] & scl_h[0]) | (scl_s[1] & scl_h[1]) | (scl_h[0] & scl_h[1]);
      sda_m <= (sda_s[1] & sda_h[0]) | (sda_s[1] & sda_h[1]) | (sda_h[0] & sda_h[1]);
    end
  assign scl   = scl_m;
  assign o_sda = sda_m;
`else
  assign scl   = scl_s[1];
  assign o_sda = sda_s[1];
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= o_sda;
    end
  assign o_scl_rise = scl & ~scl_q;
  assign o_scl_fall = ~scl & scl_q;
  // SDA edges only count as START/STOP when SCL was high on both samples
  assign o_start = scl & scl_q & sda_q & ~o_sda;
  assign o_stop  = scl & scl_q & ~sda_q & o_sda;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C register-file target with pointer byte, auto-increment and host port.
// Optional SCL/SDA glitch filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1D,
  parameter int NREG = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i2c_scl,
  inout  wire                     i2c_sda,
  input  logic                    i_host_we,
  input  logic [$clog2(NREG)-1:0] i_host_addr,
  input  logic [7:0]              i_host_wdata,
  output logic [7:0]              o_host_rdata,
  output logic                    o_wr_strobe,
  output logic [$clog2(NREG)-1:0] o_wr_addr,
  output logic [7:0]              o_wr_data,
  output logic [31:0]             o_status
);
  localparam int AW = $clog2(NREG);
  state_t state;
  logic [3:0] cnt;
  logic [7:0] sr, rd_byte;
  logic [AW-1:0] ptr, ptr_nx;
  logic [7:0] regs [NREG];
  logic rw, rack, sda_low, busy, addressed, nack;
  logic sda, scl_rise, scl_fall, start, stop;
  i2c_bus_sync u_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_scl      (i2c_scl),
    .i_sda      (i2c_sda),
    .o_sda      (sda),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_start    (start),
    .o_stop     (stop)
  );
  assign i2c_sda = sda_low ? 1'b0 : 1'bz;
  assign ptr_nx = ptr + 1'b1;
  assign rd_byte = regs[state == RDATA_ACK ? ptr_nx : ptr];
  assign o_host_rdata = regs[i_host_addr];
  always_comb begin
    o_status = '0;
    o_status[ST_BUSY] = busy;
    o_status[ST_ADDRESSED] = addressed;
    o_status[ST_NACK] = nack;
    o_status[ST_STATE_LSB +: STATE_W] = state;
  end
  // bus commit is applied one cycle after the FSM decides, on the strobe cycle, so it overrides the host
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else begin
      if (i_host_we) regs[i_host_addr] <= i_host_wdata;
      if (o_wr_strobe) regs[o_wr_addr] <= o_wr_data;
    end
  // cnt runs 7..0 then wraps to 4'hF, so cnt[3] marks a complete byte at the following SCL fall
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= 4'd7;
      sr <= 8'h00;
      ptr <= '0;
      rw <= 1'b0;
      rack <= 1'b0;
      sda_low <= 1'b0;
      busy <= 1'b0;
      addressed <= 1'b0;
      nack <= 1'b0;
      o_wr_strobe <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= 8'h00;
    end else begin
      o_wr_strobe <= 1'b0;
      if (start || stop) begin
        state <= start ? ADDR : IDLE;
        cnt <= 4'd7;
        sda_low <= 1'b0;
        busy <= start;
        addressed <= 1'b0;
      end else if (scl_rise) begin
        sr <= {sr[6:0], sda};
        cnt <= cnt - 1'b1;
        rack <= ~sda;
      end else if (scl_fall) begin
        case (state)
          ADDR: if (cnt[3]) begin
            state <= (sr[7:1] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
            sda_low <= (sr[7:1] == DEV_ADDR);
            addressed <= (sr[7:1] == DEV_ADDR);
            rw <= sr[0];
          end
          ADDR_ACK: begin
            cnt <= 4'd7;
            state <= rw ? RDATA : PTR;
            sr <= rd_byte;
            sda_low <= rw & ~rd_byte[7];
          end
          PTR: if (cnt[3]) begin
            ptr <= sr[AW-1:0];
            sda_low <= 1'b1;
            state <= PTR_ACK;
          end
          PTR_ACK: begin
            sda_low <= 1'b0;
            cnt <= 4'd7;
            state <= WDATA;
          end
          WDATA: if (cnt[3]) begin
            o_wr_strobe <= 1'b1;
            o_wr_addr <= ptr;
            o_wr_data <= sr;
            sda_low <= 1'b1;
            state <= WDATA_ACK;
          end
          WDATA_ACK: begin
            sda_low <= 1'b0;
            cnt <= 4'd7;
            ptr <= ptr_nx;
            state <= WDATA;
          end
          RDATA: begin
            sda_low <= cnt[3] ? 1'b0 : ~sr[7];
            state <= cnt[3] ? RDATA_ACK : RDATA;
          end
          RDATA_ACK: begin
            nack <= ~rack;
            state <= rack ? RDATA : WAIT_STOP;
            if (rack) begin
              ptr <= ptr_nx;
              sr <= rd_byte;
              sda_low <= ~rd_byte[7];
              cnt <= 4'd7;
            end
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: randomized bus/host transactions against a register-file model of the I2C target.
module tb_i2c_target;
  localparam int NREG = 16;
  localparam int AW = 4;
  logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0] host_wdata = 8'h00;
  wire sda_bus;
  logic [7:0] host_rdata, wr_data;
  logic wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [31:0] status;
  int n_chk = 0, n_pass = 0;
  logic [7:0] mdl [NREG];
  int mptr = 0;
  logic [11:0] strobes [$];
  pullup (sda_bus);
  assign sda_bus = sda_m ? 1'bz : 1'b0;
  always #5 clk = ~clk;
  i2c_target dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i2c_scl      (scl_m),
    .i2c_sda      (sda_bus),
    .i_host_we    (host_we),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata),
    .o_host_rdata (host_rdata),
    .o_wr_strobe  (wr_strobe),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_status     (status)
  );
  always @(negedge clk) if (wr_strobe) strobes.push_back({wr_addr, wr_data});
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bus_start;
    sda_m = 1'b1; wait_clk(8);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b0; wait_clk(8);
    scl_m = 1'b0; wait_clk(8);
  endtask
  task automatic bus_stop;
    sda_m = 1'b0; wait_clk(8);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b1; wait_clk(8);
  endtask
  task automatic bit_xfer(input logic b, input logic glitch, output logic r);
    sda_m = b; wait_clk(8);
    scl_m = 1'b1; wait_clk(6);
    if (glitch) begin
      scl_m = 1'b0; wait_clk(1);
      scl_m = 1'b1;
    end
    wait_clk(6);
    r = sda_bus;
    scl_m = 1'b0; wait_clk(8);
  endtask
  task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], i == gbit, r);
    bit_xfer(1'b1, 1'b0, r);
    ack = ~r;
  endtask
  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, r);
      b[i] = r;
    end
    bit_xfer(~ack, 1'b0, r);
  endtask
  task automatic host_write(input int a, input logic [7:0] d);
    host_we = 1'b1; host_addr = AW'(a); host_wdata = d;
    wait_clk(1);
    host_we = 1'b0;
    mdl[a] = d;
  endtask
  task automatic host_read(input int a, output logic [7:0] v);
    host_addr = AW'(a);
    #1 v = host_rdata;
  endtask
  task automatic txn_write(input logic [7:0] p, input logic [7:0] d [4], input int n, input int gbit);
    logic ack;
    logic [7:0] v;
    logic [11:0] exp [4];
    int a [4];
    strobes.delete();
    bus_start();
    write_byte(8'h3A, -1, ack); check("w_addr_ack", 32'(ack), 32'd1);
    write_byte(p, -1, ack); check("w_ptr_ack", 32'(ack), 32'd1);
    mptr = p % NREG;
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], i == 0 ? gbit : -1, ack); check("w_data_ack", 32'(ack), 32'd1);
      exp[i] = {AW'(mptr), d[i]};
      a[i] = mptr;
      mdl[mptr] = d[i];
      mptr = (mptr + 1) % NREG;
    end
    bus_stop();
    check("w_strobe_cnt", 32'(strobes.size()), 32'(n));
    for (int i = 0; i < n && i < strobes.size(); i++) check("w_strobe", 32'(strobes[i]), 32'(exp[i]));
    for (int i = 0; i < n; i++) begin
      host_read(a[i], v);
      check("w_readback", 32'(v), 32'(mdl[a[i]]));
    end
  endtask
  task automatic txn_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] b;
    strobes.delete();
    if (set_ptr) begin
      bus_start();
      write_byte(8'h3A, -1, ack); check("r_waddr_ack", 32'(ack), 32'd1);
      write_byte(p, -1, ack); check("r_ptr_ack", 32'(ack), 32'd1);
      mptr = p % NREG;
    end
    bus_start();
    write_byte(8'h3B, -1, ack); check("r_addr_ack", 32'(ack), 32'd1);
    check("r_busy_addressed", 32'(status[1:0]), 32'd3);
    for (int i = 0; i < n; i++) begin
      read_byte(i < n - 1, b);
      check("r_data", 32'(b), 32'(mdl[mptr]));
      if (i < n - 1) mptr = (mptr + 1) % NREG;
    end
    check("r_nack_flag", 32'(status[2]), 32'd1);
    bus_stop();
    check("r_idle_busy", 32'(status[0]), 32'd0);
    check("r_no_strobe", 32'(strobes.size()), 32'd0);
  endtask
  initial begin
    logic [7:0] v;
    logic [7:0] d [4];
    logic ack;
    int k;
    for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
    wait_clk(4);
    check("rst_status", status, 32'd0);
    check("rst_sda", 32'(sda_bus), 32'd1);
    check("rst_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr_data", 32'({wr_addr, wr_data}), 32'd0);
    host_read(9, v); check("rst_reg9", 32'(v), 32'd0);
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(4);
    d = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    txn_write(8'h02, d, 2, -1);
    host_write(15, 8'($urandom));
    host_write(0, 8'($urandom));
    txn_read(1'b1, 8'h0F, 2);
    strobes.delete();
    bus_start();
    write_byte(8'h42, -1, ack); check("bad_addr_nack", 32'(ack), 32'd0);
    write_byte(8'h01, -1, ack); check("bad_ptr_nack", 32'(ack), 32'd0);
    write_byte(8'hEE, -1, ack); check("bad_data_nack", 32'(ack), 32'd0);
    check("bad_not_addressed", 32'(status[1]), 32'd0);
    bus_stop();
    check("bad_no_strobe", 32'(strobes.size()), 32'd0);
    host_we = 1'b1; host_addr = AW'(1); host_wdata = 8'h77;
    d = '{8'h11, 8'h00, 8'h00, 8'h00};
    k = 0;
    fork
      txn_write(8'h01, d, 1, -1);
      begin
        while (!wr_strobe && k < 5000) begin
          @(negedge clk);
          k++;
        end
        @(negedge clk);
        host_we = 1'b0;
      end
    join
    check("collide_strobe_seen", 32'(k < 5000), 32'd1);
    host_read(1, v); check("collide_bus_wins", 32'(v), 32'h11);
    wait_clk(1);
    host_write(4, 8'h99);
    host_read(4, v); check("host_reg4", 32'(v), 32'h99);
    wait_clk(1);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    d = '{8'hC6, 8'h39, 8'h00, 8'h00};
    txn_write(8'h07, d, 2, 4);
`endif
    for (int it = 0; it < 8; it++) begin
      int op, n;
      op = $urandom_range(0, 2);
      n = $urandom_range(1, op == 0 ? 4 : 3);
      if ($urandom_range(0, 1) == 1) begin
        host_write($urandom_range(0, NREG - 1), 8'($urandom));
        wait_clk(1);
      end
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      if (op == 0) txn_write(8'($urandom), d, n, -1);
      else txn_read(op == 1, 8'($urandom), n);
    end
    host_write(5, 8'h12);
    bus_start();
    write_byte(8'h3A, -1, ack);
    write_byte(8'h05, -1, ack);
    bus_start();
    write_byte(8'h3B, -1, ack); check("mid_rd_ack", 32'(ack), 32'd1);
    check("mid_rd_drive_low", 32'(sda_bus), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_release", 32'(sda_bus), 32'd1);
    check("mid_rst_status", status, 32'd0);
    wait_clk(3);
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
    mptr = 0;
    bus_stop();
    host_read(5, v); check("mid_rst_reg5", 32'(v), 32'd0);
    wait_clk(1);
    txn_read(1'b0, 8'h00, 1);
    d = '{8'hC3, 8'h3C, 8'h00, 8'h00};
    txn_write(8'h03, d, 2, -1);
    txn_read(1'b1, 8'h03, 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
